// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data-memory responder for the DM_CS/DM_R/DM_W strobe interface (wait states enabled by DMEM_WAIT_STATE_EN)
module dmem_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int          WAIT      = 2
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        DM_CS,
  input  logic        DM_R,
  input  logic        DM_W,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  state_t state, state_nxt;
  logic [31:0] a_q, d_q, a_s, d_s, off;
  logic r_q, w_q, r_s, w_s, idle, fault, go_resp, err_q;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH];
`ifdef DMEM_WAIT_STATE_EN
  logic [3:0] cnt;
`endif
  // In IDLE the access goes straight from the pins; afterwards only the latched copy is used
  always_comb begin
    idle = state == ST_IDLE;
    a_s = idle ? addr : a_q;
    d_s = idle ? wdata : d_q;
    r_s = idle ? DM_R : r_q;
    w_s = idle ? DM_W : w_q;
    off = a_s - BASE_ADDR;
    idx = off[AW+1:2];
    fault = (a_s[1:0] != 2'b00) || ((off >> 2) >= 32'(DEPTH)) || (r_s == w_s);
`ifdef DMEM_WAIT_STATE_EN
    state_nxt = (idle && DM_CS) ? ((WAIT == 0) ? ST_RESP : ST_WAIT) :
                (state == ST_WAIT) ? ((cnt == 4'd0) ? ST_RESP : ST_WAIT) : ST_IDLE;
`else
    state_nxt = (idle && DM_CS) ? ST_RESP : ST_IDLE;
`endif
    go_resp = state_nxt == ST_RESP;
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= ST_IDLE;
      a_q   <= '0;
      d_q   <= '0;
      r_q   <= 1'b0;
      w_q   <= 1'b0;
      rdata <= '0;
      err_q <= 1'b0;
`ifdef DMEM_WAIT_STATE_EN
      cnt   <= 4'd0;
`endif
    end else begin
      state <= state_nxt;
      err_q <= go_resp && fault;
      if (idle && DM_CS) begin
        a_q <= addr;
        d_q <= wdata;
        r_q <= DM_R;
        w_q <= DM_W;
      end
      if (go_resp) rdata <= fault ? 32'h0 : mem[idx];
`ifdef DMEM_WAIT_STATE_EN
      cnt <= idle ? 4'(WAIT - 1) : ((cnt == 4'd0) ? cnt : cnt - 4'd1);
`endif
    end
  end
  // Memory is never reset; a reset on the commit edge suppresses the write
  always_ff @(posedge clk_in) begin
    if (!reset && go_resp && !fault && w_s) mem[idx] <= d_s;
  end
  assign ready = state == ST_RESP;
  assign err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
module tb_dmem_responder;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h1001_0000;
`ifdef DMEM_WAIT_STATE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  logic clk = 1'b0, reset = 1'b1, DM_CS = 1'b0, DM_R = 1'b0, DM_W = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic ready, err;
  int pass_cnt = 0, total = 0;

  dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT(2)) dut (
    .clk_in(clk), .reset(reset), .DM_CS(DM_CS), .DM_R(DM_R), .DM_W(DM_W),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err)
  );

  always #5 clk = ~clk;

  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int k, output logic e, output logic [31:0] q);
    @(negedge clk);
    DM_CS = 1'b1; DM_R = r; DM_W = w; addr = a; wdata = d;
    @(posedge clk); #1;
    DM_CS = 1'b0; DM_R = 1'b1; DM_W = 1'b1; addr = ~a; wdata = ~d;
    k = 0; e = 1'bx; q = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ready) begin k = i; e = err; q = rdata; break; end
    end
    DM_R = 1'b0; DM_W = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    total++; if (ready !== 1'b0) $display("FAIL reset_ready got %b want 0", ready); else pass_cnt++;
    total++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else pass_cnt++;
    total++; if (rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", rdata); else pass_cnt++;
  endtask

  task automatic test_write_read;
    int k; logic e; logic [31:0] q;
    access(1'b0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, k, e, q);
    total++; if (k !== LAT + 1) $display("FAIL wr_latency got %0d want %0d", k, LAT + 1); else pass_cnt++;
    total++; if (e !== 1'b0) $display("FAIL wr_err got %b want 0", e); else pass_cnt++;
    @(negedge clk);
    total++; if (ready !== 1'b0 || err !== 1'b0) $display("FAIL wr_pulse ready=%b err=%b want 0 0", ready, err); else pass_cnt++;
    access(1'b1, 1'b0, 32'h1001_0004, 32'h0, k, e, q);
    total++; if (k !== LAT + 1) $display("FAIL rd_latency got %0d want %0d", k, LAT + 1); else pass_cnt++;
    total++; if (e !== 1'b0 || q !== 32'hDEAD_BEEF) $display("FAIL rd_data err=%b got %h want 0 deadbeef", e, q); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int k; logic e; logic [31:0] q;
    access(1'b0, 1'b1, BASE, 32'h0000_0001, k, e, q);
    access(1'b1, 1'b0, BASE, 32'h0, k, e, q);
    total++; if (k !== LAT + 1 || q !== 32'h1) $display("FAIL zw_read lat=%0d data=%h want %0d 00000001", k, q, LAT + 1); else pass_cnt++;
    @(negedge clk);
    DM_CS = 1'b1; DM_R = 1'b1; DM_W = 1'b0; addr = BASE;
    for (int i = 1; i <= 3 * (LAT + 2); i++) begin
      @(negedge clk);
      total++;
      if (ready !== ((i % (LAT + 2)) == LAT + 1))
        $display("FAIL held_cs cycle %0d ready got %b want %b", i, ready, (i % (LAT + 2)) == LAT + 1);
      else pass_cnt++;
    end
    DM_CS = 1'b0; DM_R = 1'b0;
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic test_misaligned;
    int k; logic e; logic [31:0] q;
    access(1'b0, 1'b1, 32'h1001_0002, 32'h1234_5678, k, e, q);
    total++; if (k !== LAT + 1 || e !== 1'b1 || q !== 32'h0) $display("FAIL misaligned lat=%0d err=%b rdata=%h want %0d 1 0", k, e, q, LAT + 1); else pass_cnt++;
    access(1'b1, 1'b0, BASE, 32'h0, k, e, q);
    total++; if (e !== 1'b0 || q !== 32'h1) $display("FAIL misaligned_keep err=%b got %h want 0 00000001", e, q); else pass_cnt++;
  endtask

  task automatic test_range;
    int k; logic e; logic [31:0] q;
    access(1'b1, 1'b0, 32'h1001_1000, 32'h0, k, e, q);
    total++; if (e !== 1'b1 || q !== 32'h0) $display("FAIL range_high err=%b rdata=%h want 1 0", e, q); else pass_cnt++;
    access(1'b1, 1'b0, 32'h1000_FFFC, 32'h0, k, e, q);
    total++; if (e !== 1'b1 || q !== 32'h0) $display("FAIL range_below err=%b rdata=%h want 1 0", e, q); else pass_cnt++;
    access(1'b0, 1'b1, 32'h1001_0FFC, 32'hCAFE_F00D, k, e, q);
    access(1'b1, 1'b0, 32'h1001_0FFC, 32'h0, k, e, q);
    total++; if (e !== 1'b0 || q !== 32'hCAFE_F00D) $display("FAIL range_top err=%b rdata=%h want 0 cafef00d", e, q); else pass_cnt++;
  endtask

  task automatic test_strobes;
    int k; logic e; logic [31:0] q;
    access(1'b1, 1'b1, BASE, 32'hFFFF_0000, k, e, q);
    total++; if (k !== LAT + 1 || e !== 1'b1 || q !== 32'h0) $display("FAIL both_strobes lat=%0d err=%b rdata=%h want %0d 1 0", k, e, q, LAT + 1); else pass_cnt++;
    access(1'b0, 1'b0, BASE, 32'hFFFF_0000, k, e, q);
    total++; if (k !== LAT + 1 || e !== 1'b1) $display("FAIL no_strobe lat=%0d err=%b want %0d 1", k, e, LAT + 1); else pass_cnt++;
    access(1'b1, 1'b0, BASE, 32'h0, k, e, q);
    total++; if (e !== 1'b0 || q !== 32'h1) $display("FAIL strobe_keep err=%b got %h want 0 00000001", e, q); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int k, seen; logic e; logic [31:0] q;
    access(1'b0, 1'b1, 32'h1001_0008, 32'h1111_2222, k, e, q);
    @(negedge clk);
    DM_CS = 1'b1; DM_R = 1'b0; DM_W = 1'b1; addr = 32'h1001_0008; wdata = 32'hA5A5_A5A5;
    if (LAT == 0) reset = 1'b1;
    @(posedge clk); #1;
    DM_CS = 1'b0; DM_W = 1'b0;
    if (LAT > 0) begin @(negedge clk); reset = 1'b1; end
    @(negedge clk);
    reset = 1'b0;
    total++; if (ready !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) $display("FAIL mid_reset_out ready=%b err=%b rdata=%h want 0 0 0", ready, err, rdata); else pass_cnt++;
    seen = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (ready) seen++; end
    total++; if (seen !== 0) $display("FAIL mid_reset_ready got %0d pulses want 0", seen); else pass_cnt++;
    access(1'b1, 1'b0, 32'h1001_0008, 32'h0, k, e, q);
    total++; if (e !== 1'b0 || q !== 32'h1111_2222) $display("FAIL mid_reset_mem err=%b got %h want 0 11112222", e, q); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_back_to_back;
    test_misaligned;
    test_range;
    test_strobes;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
